// File: rtl/sipo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sipo_ctrl_pkg
// Shared definitions for the serial-in / parallel-out receive controller:
//   state_e          - receive FSM state encoding (IDLE, SHIFT, PARITY)
//   PARITY_NONE/EVEN - values accepted by the PARITY_EN parameter
//   even_parity_err  - even-parity check over a zero-extended data word
// ---------------------------------------------------------------------------
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  // Returns 1 when data bits plus the received parity bit hold an odd count
  // of ones, i.e. the even-parity check fails. Callers zero-extend the word,
  // which does not change its XOR reduction.
  function automatic logic even_parity_err(input logic [31:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// sipo_rx_ctrl_if
// Bundles the serial input, output handshake and status of sipo_rx_ctrl.
//   start      - frame-start strobe
//   sdata      - serial data bit, LSB first
//   sbit_en    - bit strobe qualifying sdata
//   busy       - frame in progress
//   par_data   - received parallel word (WIDTH bits)
//   par_valid  - par_data / parity_err valid
//   par_ready  - consumer accepts par_data
//   parity_err - parity mismatch of the held word
//   overrun    - sticky dropped-frame flag
//   clr_ovr    - clears overrun
// Modports: master = the side feeding bits and consuming words,
//           slave  = the receiver itself.
// ---------------------------------------------------------------------------
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sdata;
  logic             sbit_en;
  logic             busy;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             parity_err;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output start, sdata, sbit_en, par_ready, clr_ovr,
    input  busy, par_data, par_valid, parity_err, overrun
  );

  modport slave (
    input  start, sdata, sbit_en, par_ready, clr_ovr,
    output busy, par_data, par_valid, parity_err, overrun
  );

endinterface

// File: rtl/sipo_shreg.sv
// ---------------------------------------------------------------------------
// sipo_shreg
// WIDTH-bit enabled serial-in parallel-out register. Each enabled cycle
// shifts sin_i into the MSB and moves the word right, so the first bit
// received ends up in bit 0 after WIDTH shifts.
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; clears the register
//   en_i  - shift enable
//   sin_i - serial input
//   q_o   - parallel register contents
// ---------------------------------------------------------------------------
module sipo_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: shift right with new bit at the MSB, or hold.
  always_comb begin
    if (en_i) begin
      q_d = {sin_i, q_q[WIDTH-1:1]};
    end else begin
      q_d = q_q;
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_rx_ctrl
// Serial receive controller: after a start strobe it collects WIDTH bits
// (LSB first) on sbit_en strobes, optionally checks one even-parity bit,
// and hands the word to a valid/ready output register. A word completing
// while the output is still occupied and not being accepted is dropped and
// the sticky overrun flag is raised.
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - sipo_rx_ctrl_if slave modport (start, sdata, sbit_en, busy,
//           par_data, par_valid, par_ready, parity_err, overrun, clr_ovr)
// Parameters:
//   WIDTH     - data bits per frame (2..32)
//   PARITY_EN - PARITY_EVEN expects a parity bit after the data,
//               PARITY_NONE completes the frame on the last data bit
// ---------------------------------------------------------------------------
module sipo_rx_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  sipo_rx_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic             shift_en_s;
  logic             last_data_s;
  logic [WIDTH-1:0] shreg_s;
  logic             done_s;
  logic [WIDTH-1:0] word_s;
  logic             perr_s;
  logic             load_s;
  logic             drop_s;

  logic [WIDTH-1:0] par_data_q;
  logic [WIDTH-1:0] par_data_d;
  logic             par_valid_q;
  logic             par_valid_d;
  logic             parity_err_q;
  logic             parity_err_d;
  logic             overrun_q;
  logic             overrun_d;

  // Bits are only sampled in SHIFT; the start cycle never shifts.
  assign shift_en_s  = (state_q == ST_SHIFT) && bus.sbit_en;
  assign last_data_s = shift_en_s && (cnt_q == LAST_BIT);

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .en_i  (shift_en_s),
    .sin_i (bus.sdata),
    .q_o   (shreg_s)
  );

  // Frame completion and the word/parity result it delivers. Without parity
  // the frame ends on the last data strobe, so the word is the register's
  // next value rather than its current contents.
  always_comb begin
    done_s = 1'b0;
    word_s = shreg_s;
    case (state_q)
      ST_SHIFT: begin
        if (last_data_s && (PARITY_EN != PARITY_EVEN)) begin
          done_s = 1'b1;
          word_s = {bus.sdata, shreg_s[WIDTH-1:1]};
        end else begin
          done_s = 1'b0;
        end
      end
      ST_PARITY: begin
        if (bus.sbit_en) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
    if (PARITY_EN == PARITY_EVEN) begin
      perr_s = even_parity_err(32'(word_s), bus.sdata);
    end else begin
      perr_s = 1'b0;
    end
  end

  // Receive FSM with bit counter and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_SHIFT;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (bus.sbit_en) begin
            // Counter stops at WIDTH; it is reloaded on the next start.
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              if (PARITY_EN == PARITY_EVEN) begin
                state_q <= ST_PARITY;
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end
        end
        ST_PARITY: begin
          if (bus.sbit_en) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_PARITY;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A completed word may enter the output stage if it is empty or being
  // drained this cycle; otherwise it is dropped and counted as overrun.
  assign load_s = done_s && (!par_valid_q || bus.par_ready);
  assign drop_s = done_s && par_valid_q && !bus.par_ready;

  // Output stage and sticky overrun next-state.
  always_comb begin
    par_data_d   = par_data_q;
    parity_err_d = parity_err_q;
    par_valid_d  = par_valid_q;
    overrun_d    = overrun_q;
    if (load_s) begin
      par_data_d   = word_s;
      parity_err_d = perr_s;
      par_valid_d  = 1'b1;
    end else if (par_valid_q && bus.par_ready) begin
      par_valid_d  = 1'b0;
    end else begin
      par_valid_d  = par_valid_q;
    end
    // Set has priority over a simultaneous clear.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_data_q   <= {WIDTH{1'b0}};
      par_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      par_data_q   <= par_data_d;
      par_valid_q  <= par_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.par_data   = par_data_q;
  assign bus.par_valid  = par_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/sipo_rx_ctrl.md
SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 1, which when 1 expects one even-parity bit after the data bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  frame-start strobe, honoured only in IDLE.
REQ-006 SHALL have port sdata  input  1  serial data bit, LSB first.
REQ-007 SHALL have port sbit_en  input  1  bit strobe; sdata is sampled only when this is 1.
REQ-008 SHALL have port busy  output  1  frame in progress.
REQ-009 SHALL have port par_data  output  WIDTH  received parallel word.
REQ-010 SHALL have port par_valid  output  1  par_data and parity_err valid.
REQ-011 SHALL have port par_ready  input  1  consumer accepts par_data.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for the held word; always 0 when PARITY_EN=0.
REQ-013 SHALL have port overrun  output  1  sticky flag: a completed frame was dropped.
REQ-014 SHALL have port clr_ovr  input  1  clears overrun.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and PARITY; busy SHALL equal (state != IDLE).
REQ-016 SHALL go IDLE->SHIFT on start=1 and clear the bit counter; sdata is not sampled in that cycle, even if sbit_en=1.
REQ-017 SHALL ignore start in SHIFT and PARITY.
REQ-018 SHALL, in SHIFT, shift sdata into the MSB and move the register right on each sbit_en, so that the first bit received ends in bit 0; cycles without sbit_en hold all state.
REQ-019 SHALL, on the WIDTH-th strobe, go SHIFT->PARITY if PARITY_EN=1; otherwise the frame completes on that strobe.
REQ-020 SHALL, in PARITY, complete the frame on the next strobe, with parity error = XOR(data bits, parity bit).
REQ-021 SHALL return to IDLE in the cycle after frame completion; start is accepted from that IDLE cycle onward.
REQ-022 SHALL load the completed word into the output register if par_valid=0 or (par_valid & par_ready); par_valid then rises one cycle after the final strobe.
REQ-023 SHALL hold par_data and parity_err stable while par_valid=1 and par_ready=0.
REQ-024 SHALL clear par_valid on par_valid & par_ready, unless a new word loads in the same cycle, in which case par_valid stays 1 with the new data.
REQ-025 SHALL, on completion when the output is occupied and not being accepted, drop the word, leave the output unchanged and set overrun.
REQ-026 SHALL clear overrun on clr_ovr=1; if a set and a clear occur in the same cycle, set wins.
REQ-027 SHALL size the bit counter as $clog2(WIDTH+1) bits; it never wraps within a frame.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, counter=0, shift register=0, par_data=0, par_valid=0, parity_err=0 and overrun=0, independent of clk.
REQ-029 SHALL discard a frame in progress when reset is asserted mid-frame; no par_valid results from it.

Structure
REQ-030 SHALL take the state enumeration and parity-mode constants from shared package sipo_ctrl_pkg.
REQ-031 SHALL instantiate one sub-module, sipo_shreg: a WIDTH-bit enabled serial-in parallel-out register with async active-high reset.

Verification (WIDTH=8, PARITY_EN=1)
REQ-032 SHALL cover: start, then bits 1,0,1,0,0,1,0,1 and parity 0 -> par_valid=1 one cycle after the parity strobe, par_data=0xA5, parity_err=0.
REQ-033 SHALL cover: the same frame with parity bit 1 -> par_data=0xA5, parity_err=1.
REQ-034 SHALL cover: par_ready=0, frames 0x3C then 0xC3 -> par_data stays 0x3C, overrun=1; pulse clr_ovr -> overrun=0.
REQ-035 SHALL cover: 0x3C pending, second frame 0x5A completing while par_ready=1 -> par_valid stays 1, par_data=0x5A, overrun=0.
REQ-036 SHALL cover: reset asserted after 4 bits -> busy=0, par_valid=0; next frame 0x81 received correctly.
REQ-037 SHALL cover: start pulses during SHIFT plus random gaps in sbit_en with frame 0x96 -> par_data=0x96, parity_err=0.
